// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM state and memory-command payload for the memory-access stage.
// The opcode is taken from Ins[31:26].
package mem_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned BEW  = XLEN / 8;

  localparam logic [OPW-1:0] OP_LB  = 6'h20;
  localparam logic [OPW-1:0] OP_LH  = 6'h21;
  localparam logic [OPW-1:0] OP_LW  = 6'h23;
  localparam logic [OPW-1:0] OP_LBU = 6'h24;
  localparam logic [OPW-1:0] OP_LHU = 6'h25;
  localparam logic [OPW-1:0] OP_SB  = 6'h28;
  localparam logic [OPW-1:0] OP_SH  = 6'h29;
  localparam logic [OPW-1:0] OP_SW  = 6'h2B;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BEW-1:0]  be;
    logic [XLEN-1:0] wdata;
  } dmem_cmd_t;

  function automatic size_e op_size(input logic [OPW-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [OPW-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_signed(input logic [OPW-1:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Big-endian lane select and sign/zero extension of load data.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_i,
  input  logic [OPW-1:0]  op_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[31:24];
    half_sel = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    // Byte 0 lives in the most significant lane.
    case (addr_i)
      2'd0: byte_sel = rdata_i[31:24];
      2'd1: byte_sel = rdata_i[23:16];
      2'd2: byte_sel = rdata_i[15:8];
      2'd3: byte_sel = rdata_i[7:0];
      default: byte_sel = rdata_i[31:24];
    endcase

    data_o = rdata_i;
    case (op_size(op_i))
      SZ_BYTE: data_o = op_is_signed(op_i) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      SZ_HALF: data_o = op_is_signed(op_i) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: load/store over a req/ack data-memory port, registered write-back.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] Ins,
  input  logic [XLEN-1:0] Result,
  input  logic [XLEN-1:0] Rdata2,
  input  logic            valid_in,
  output logic            stall,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [BEW-1:0]  dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] Wdata,
  output logic            Wvalid,
  output logic            mem_err
);

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_e          state_q;
  dmem_cmd_t       cmd_q;
  logic            req_q;
  logic [OPW-1:0]  op_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] wb_q;
  logic            wvalid_q;
  logic            err_q;

  logic [OPW-1:0]  op_c;
  size_e           size_c;
  logic            is_mem_c;
  logic            aligned_c;
  logic [BEW-1:0]  be_c;
  logic [XLEN-1:0] wdata_c;
  logic            accept_c;
  logic            expire_c;
  logic [XLEN-1:0] load_c;
  logic            unused_ins;

  assign unused_ins = ^Ins[25:0];

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q;
  assign expire_c = (state_q == ST_ACCESS) && !dmem_ack && (cnt_q == TO_LAST);
`else
  assign expire_c = 1'b0;
`endif

  // Instruction decode, alignment, byte enables and store-lane replication.
  always_comb begin
    op_c      = Ins[31:26];
    size_c    = op_size(op_c);
    is_mem_c  = (size_c != SZ_NONE);
    aligned_c = 1'b1;
    be_c      = 4'b1111;
    wdata_c   = Rdata2;
    case (size_c)
      SZ_BYTE: begin
        be_c    = 4'(4'b1000 >> Result[1:0]);
        wdata_c = {4{Rdata2[7:0]}};
      end
      SZ_HALF: begin
        aligned_c = !Result[0];
        be_c      = Result[1] ? 4'b0011 : 4'b1100;
        wdata_c   = {2{Rdata2[15:0]}};
      end
      SZ_WORD: aligned_c = (Result[1:0] == 2'b00);
      default: ;
    endcase
    accept_c = (state_q == ST_IDLE) && valid_in && is_mem_c && aligned_c;
  end

  assign stall = accept_c || ((state_q == ST_ACCESS) && !dmem_ack && !expire_c);

  mem_load_align u_load_align (
    .rdata_i (dmem_rdata),
    .addr_i  (lane_q),
    .op_i    (op_q),
    .data_o  (load_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      req_q    <= 1'b0;
      op_q     <= '0;
      lane_q   <= '0;
      wb_q     <= '0;
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      wvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_in) begin
            if (!is_mem_c) begin
              wb_q     <= Result;
              wvalid_q <= 1'b1;
            end else if (aligned_c) begin
              cmd_q.we    <= op_is_store(op_c);
              cmd_q.addr  <= {Result[31:2], 2'b00};
              cmd_q.be    <= be_c;
              cmd_q.wdata <= wdata_c;
              op_q        <= op_c;
              lane_q      <= Result[1:0];
              req_q       <= 1'b1;
              state_q     <= ST_ACCESS;
`ifdef MEM_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          if (dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
            if (!cmd_q.we) begin
              wb_q     <= load_c;
              wvalid_q <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
          end else if (expire_c) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = cmd_q.we;
  assign dmem_addr  = cmd_q.addr;
  assign dmem_be    = cmd_q.be;
  assign dmem_wdata = cmd_q.wdata;
  assign Wdata      = wb_q;
  assign Wvalid     = wvalid_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, random transactions against
// an arithmetic reference model, reset-abort and (with MEM_TIMEOUT_EN) watchdog sequences.
module tb_mem_stage;

  localparam int K_PASS  = 0;
  localparam int K_LOAD  = 1;
  localparam int K_STORE = 2;
  localparam int K_MIS   = 3;

  localparam logic [5:0] T_LB = 6'h20, T_LH = 6'h21, T_LW = 6'h23, T_LBU = 6'h24;
  localparam logic [5:0] T_LHU = 6'h25, T_SB = 6'h28, T_SH = 6'h29, T_SW = 6'h2B;
  localparam logic [5:0] T_ADD = 6'h00;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins, Result, Rdata2, dmem_rdata;
  logic        valid_in, dmem_ack;
  logic        stall, dmem_req, dmem_we, Wvalid, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, Wdata;
  logic [3:0]  dmem_be;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .valid_in(valid_in), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .Wdata(Wdata), .Wvalid(Wvalid),
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: access size in bytes (0 = not a memory op).
  function automatic int m_size(input logic [5:0] op);
    if (op == T_LB || op == T_LBU || op == T_SB) return 1;
    if (op == T_LH || op == T_LHU || op == T_SH) return 2;
    if (op == T_LW || op == T_SW) return 4;
    return 0;
  endfunction

  function automatic int m_kind(input logic [5:0] op, input logic [31:0] addr);
    int sz = m_size(op);
    if (sz == 0) return K_PASS;
    if ((int'(addr[1:0]) % sz) != 0) return K_MIS;
    if (op == T_SB || op == T_SH || op == T_SW) return K_STORE;
    return K_LOAD;
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] addr);
    logic [3:0] b = '0;
    int sz = m_size(op);
    int base = int'(addr[1:0]);
    for (int i = 0; i < sz; i++) b[3 - (base + i)] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] rd2);
    case (m_size(op))
      1: return (rd2 & 32'hFF) * 32'h0101_0101;
      2: return (rd2 & 32'hFFFF) * 32'h0001_0001;
      default: return rd2;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int sz = m_size(op);
    int shamt = 8 * (4 - sz - int'(addr[1:0]));
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    logic [31:0] v = (rdata >> shamt) & mask;
    logic [31:0] top = (mask >> 1) + 32'd1;
    if ((op == T_LB || op == T_LH) && ((v & top) != 0)) v = v | ~mask;
    return v;
  endfunction

  // One instruction through the stage; starts and ends just after a rising edge.
  task automatic run_txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] rd2, input logic [31:0] rdata, input int delay,
                         input int kind, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] ewb);
    logic busy;
    busy       = (kind == K_LOAD) || (kind == K_STORE);
    Ins        = {op, 26'($urandom)};
    Result     = addr;
    Rdata2     = rd2;
    valid_in   = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = rdata;
    @(negedge CLK);
    check({tag, " stall_c0"}, 32'(stall), 32'(busy));
    check({tag, " req_c0"}, 32'(dmem_req), 32'd0);
    step();
    if (!busy) begin
      valid_in = 1'b0;
      @(negedge CLK);
      check({tag, " wvalid"}, 32'(Wvalid), 32'(kind == K_PASS));
      check({tag, " err"}, 32'(mem_err), 32'(kind == K_MIS));
      check({tag, " req"}, 32'(dmem_req), 32'd0);
      if (kind == K_PASS) check({tag, " wdata"}, Wdata, ewb);
    end else begin
      for (int k = 0; k <= delay; k++) begin
        dmem_ack = (k == delay);
        @(negedge CLK);
        check({tag, " req"}, 32'(dmem_req), 32'd1);
        check({tag, " we"}, 32'(dmem_we), 32'(kind == K_STORE));
        check({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
        check({tag, " be"}, 32'(dmem_be), 32'(ebe));
        if (kind == K_STORE) check({tag, " dwdata"}, dmem_wdata, ewd);
        check({tag, " stall"}, 32'(stall), 32'(k != delay));
        check({tag, " wvalid_busy"}, 32'(Wvalid), 32'd0);
        step();
      end
      dmem_ack = 1'b0;
      valid_in = 1'b0;
      @(negedge CLK);
      check({tag, " req_done"}, 32'(dmem_req), 32'd0);
      check({tag, " wvalid"}, 32'(Wvalid), 32'(kind == K_LOAD));
      check({tag, " err"}, 32'(mem_err), 32'd0);
      if (kind == K_LOAD) check({tag, " wdata"}, Wdata, ewb);
    end
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"}, 32'(dmem_req), 32'd0);
    check({tag, " we"}, 32'(dmem_we), 32'd0);
    check({tag, " be"}, 32'(dmem_be), 32'd0);
    check({tag, " addr"}, dmem_addr, 32'd0);
    check({tag, " dwdata"}, dmem_wdata, 32'd0);
    check({tag, " wdata"}, Wdata, 32'd0);
    check({tag, " wvalid"}, 32'(Wvalid), 32'd0);
    check({tag, " err"}, 32'(mem_err), 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] rdata;
    int          delay;
    int          kind;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wb;
  } vec_t;

  vec_t vecs[12];
  logic [5:0] rops[10];

  initial begin
    vecs[0]  = '{T_ADD, 32'h0000_1234, 32'h0,         32'h0,         0, K_PASS,  4'b0000, 32'h0,         32'h0000_1234};
    vecs[1]  = '{T_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, K_LOAD,  4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{T_LB,  32'h0000_0103, 32'h0,         32'h1122_3380, 0, K_LOAD,  4'b0001, 32'h0,         32'hFFFF_FF80};
    vecs[3]  = '{T_LBU, 32'h0000_0103, 32'h0,         32'h1122_3380, 1, K_LOAD,  4'b0001, 32'h0,         32'h0000_0080};
    vecs[4]  = '{T_SH,  32'h0000_0102, 32'hAAAA_5A5A, 32'h0,         3, K_STORE, 4'b0011, 32'h5A5A_5A5A, 32'h0};
    vecs[5]  = '{T_LH,  32'h0000_0102, 32'h0,         32'h1122_8344, 0, K_LOAD,  4'b0011, 32'h0,         32'hFFFF_8344};
    vecs[6]  = '{T_LHU, 32'h0000_0100, 32'h0,         32'h8344_1122, 2, K_LOAD,  4'b1100, 32'h0,         32'h0000_8344};
    vecs[7]  = '{T_SB,  32'h0000_0101, 32'h1234_56CD, 32'h0,         0, K_STORE, 4'b0100, 32'hCDCD_CDCD, 32'h0};
    vecs[8]  = '{T_SW,  32'h0000_010C, 32'h1234_5678, 32'h0,         1, K_STORE, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[9]  = '{T_LW,  32'h0000_0101, 32'h0,         32'h0,         0, K_MIS,   4'b0000, 32'h0,         32'h0};
    vecs[10] = '{T_LH,  32'h0000_0103, 32'h0,         32'h0,         0, K_MIS,   4'b0000, 32'h0,         32'h0};
    vecs[11] = '{T_LB,  32'h0000_0100, 32'h0,         32'h7F00_0000, 0, K_LOAD,  4'b1000, 32'h0,         32'h0000_007F};
    rops = '{T_ADD, 6'h0F, T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};

    RST = 1'b1; valid_in = 1'b0; dmem_ack = 1'b0;
    Ins = '0; Result = '0; Rdata2 = '0; dmem_rdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_all_zero("reset");
    check("reset stall", 32'(stall), 32'd0);
    step();
    RST = 1'b0;
    step();

    for (int i = 0; i < 12; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rd2, vecs[i].rdata,
              vecs[i].delay, vecs[i].kind, vecs[i].be, vecs[i].wd, vecs[i].wb);

    // Ack while idle must be ignored.
    dmem_ack = 1'b1;
    @(negedge CLK);
    step();
    dmem_ack = 1'b0;
    @(negedge CLK);
    check("idle_ack wvalid", 32'(Wvalid), 32'd0);
    check("idle_ack req", 32'(dmem_req), 32'd0);
    step();

    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] a, d2, rd;
      op = rops[$urandom_range(0, 9)];
      a  = $urandom;
      d2 = $urandom;
      rd = $urandom;
      run_txn($sformatf("rnd%0d", i), op, a, d2, rd, int'($urandom_range(0, 3)), m_kind(op, a),
              m_be(op, a), m_wdata(op, d2), (m_size(op) == 0) ? a : m_load(op, a, rd));
    end

    // Reset while an access is outstanding abandons it; a late ack is ignored.
    Ins = {T_LW, 26'd0}; Result = 32'h0000_0200; valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_acc req_before", 32'(dmem_req), 32'd1);
    step();
    RST = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    check_all_zero("rst_acc");
    check("rst_acc stall", 32'(stall), 32'd0);
    step();
    dmem_ack = 1'b0;
    @(negedge CLK);
    check("rst_acc late_ack wvalid", 32'(Wvalid), 32'd0);
    check("rst_acc late_ack req", 32'(dmem_req), 32'd0);
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: request held for 4 access cycles, then error and back to idle.
    Ins = {T_LW, 26'd0}; Result = 32'h0000_0300; valid_in = 1'b1;
    @(negedge CLK);
    check("to stall_c0", 32'(stall), 32'd1);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check($sformatf("to req_k%0d", k), 32'(dmem_req), 32'd1);
      check($sformatf("to stall_k%0d", k), 32'(stall), 32'(k != 3));
      step();
    end
    valid_in = 1'b0;
    @(negedge CLK);
    check("to req_after", 32'(dmem_req), 32'd0);
    check("to err", 32'(mem_err), 32'd1);
    check("to wvalid", 32'(Wvalid), 32'd0);
    step();
    @(negedge CLK);
    check("to err_pulse", 32'(mem_err), 32'd0);
    step();
    run_txn("to_ackwins", T_LW, 32'h0000_0304, 32'h0, 32'h0102_0304, 3, K_LOAD,
            4'b1111, 32'h0, 32'h0102_0304);
`else
    run_txn("longwait", T_LW, 32'h0000_0304, 32'h0, 32'h0102_0304, 9, K_LOAD,
            4'b1111, 32'h0, 32'h0102_0304);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its Result (effective address or ALU value), the instruction and Rdata2 (store data).
- Runs loads/stores against a data-memory port with a req/ack handshake and stalls upstream while an access is outstanding.
- Produces registered write-back data with a valid strobe.
- Big-endian byte lanes. Supported ops: LB, LBU, LH, LHU, LW, SB, SH, SW; all other instructions pass through.

Parameters:
- TIMEOUT_CYCLES, 64: ack watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- Ins  in  32  instruction from execute stage.
- Result  in  32  address/ALU result from execute stage.
- Rdata2  in  32  store data.
- valid_in  in  1  Ins/Result/Rdata2 are valid this cycle.
- stall  out  1  upstream must hold its inputs stable.
- dmem_req  out  1  memory request (registered).
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address: Result with bits [1:0] forced to 0.
- dmem_be  out  4  byte enables; bit 3 = bits [31:24].
- dmem_wdata  out  32  lane-aligned store data.
- dmem_ack  in  1  access complete; rdata valid in the same cycle.
- dmem_rdata  in  32  load data.
- Wdata  out  32  write-back value (registered).
- Wvalid  out  1  one-cycle strobe for Wdata.
- mem_err  out  1  one-cycle error pulse.

Behaviour:
- Interface: one clock CLK. RST is synchronous and active-high.
- Reset: state = IDLE. All outputs are 0: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, Wdata, Wvalid, mem_err.
- FSM has two states, IDLE and ACCESS.
- IDLE, valid_in with a non-memory op:
  - next edge: Wdata <= Result, Wvalid <= 1.
  - latency 1 cycle; no stall.
- IDLE, valid_in with a memory op and an aligned address:
  - next edge: latch we/addr/be/wdata/op, go to ACCESS, dmem_req <= 1.
- Alignment rules:
  - Halfword ops require Result[0] = 0.
  - Word ops require Result[1:0] = 0.
  - Byte ops are always aligned.
- IDLE, valid_in with a misaligned memory op:
  - no request; next edge mem_err <= 1 for one cycle, Wvalid <= 0.
  - instruction is consumed; no stall.
- ACCESS:
  - dmem_req stays high; addr/we/be/wdata stay stable until the edge at which dmem_ack = 1 is sampled.
  - At that edge: dmem_req <= 0, go to IDLE.
  - Load: Wdata <= extracted data, Wvalid <= 1.
  - Store: Wvalid <= 0.
- stall (combinational) = (IDLE & valid_in & mem op & aligned) | (ACCESS & ~dmem_ack). Upstream advances in the cycle ack is seen.
- Minimum memory-op latency: accept at cycle 0, req+ack at cycle 1, Wvalid at cycle 2.
- Back-to-back: a new instruction presented in the ack cycle is not accepted until the following cycle (IDLE). There is no bubble-free chaining.
- dmem_ack while in IDLE is ignored.
- Byte enables, big-endian:
  - byte ops: addr[1:0] = 0,1,2,3 -> be = 1000, 0100, 0010, 0001.
  - halfword ops: addr[1] = 0,1 -> be = 1100, 0011.
  - word ops: be = 1111.
- Store data:
  - SB: Rdata2[7:0] replicated into all 4 lanes.
  - SH: Rdata2[15:0] replicated into both halves.
  - SW: Rdata2 unchanged.
- Load extraction: select the lane per addr[1:0] using the big-endian mapping. LB/LH sign-extend; LBU/LHU zero-extend.
- RST asserted in ACCESS: next edge returns to IDLE with all outputs 0. The pending access is abandoned and any late ack is ignored.
- valid_in = 0 in IDLE: Wvalid <= 0 and mem_err <= 0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: dmem_req <= 0, go to IDLE, mem_err pulses one cycle, Wvalid = 0, stall deasserts in that cycle.
  - Ack in the same cycle as expiry: the ack wins.
- Undefined: no counter; ACCESS waits indefinitely; mem_err only reports misalignment.

Decomposition:
- Add to common_param.vh: opcodes LB 6'h20, LH 6'h21, LW 6'h23, LBU 6'h24, LHU 6'h25, SB 6'h28, SH 6'h29, SW 6'h2B; FSM state encodings IDLE/ACCESS.
- One combinational sub-module, mem_load_align: inputs rdata, addr[1:0], op; output the 32-bit extended load value.
- Byte-enable and store-lane generation stay inline.

Test Plan:
- Pass-through: ADD with Result=32'h0000_1234 -> next cycle Wdata=32'h0000_1234, Wvalid=1, stall never asserted, dmem_req=0.
- LW 0x100 with ack on the first req cycle, rdata=32'hDEAD_BEEF -> req at cycle 1 with addr=0x100, be=1111; Wdata=32'hDEAD_BEEF, Wvalid at cycle 2; stall high in cycle 0 only.
- LB 0x103 and LBU 0x103, rdata=32'h1122_3380 -> be=0001; Wdata=32'hFFFF_FF80 for LB, 32'h0000_0080 for LBU.
- SH 0x102, Rdata2=32'hAAAA_5A5A, ack delayed 3 cycles -> dmem_we=1, be=0011, wdata=32'h5A5A_5A5A held stable for 4 req cycles; stall high throughout; Wvalid=0.
- LW 0x101 (misaligned) -> no req, mem_err one-cycle pulse, no stall; RST during ACCESS -> next edge dmem_req=0, all outputs 0, a subsequent ack is ignored.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 ACCESS cycles, mem_err pulses, FSM back in IDLE.
